// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard scoreboard: stage entry layout, forwarding select encoding.
// Optional feature macro used by the top: HAZARD_FWD_EN.
package hazard_pkg;

  localparam int N = 5;
  localparam logic [N-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic         v;
    logic [N-1:0] rd;
    logic         wr;
    logic         ld;
  } stage_ent_t;

  localparam stage_ent_t BUBBLE = '0;

  // hit[0]=EX, hit[1]=MEM, hit[2]=WB; the youngest producer wins
  function automatic fwd_sel_t pick_fwd(input logic [2:0] hit);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (hit[0])      sel = FWD_EX;
    else if (hit[1]) sel = FWD_MEM;
    else if (hit[2]) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_match.sv
// Compares one source register against one pipeline stage entry.
// A hit needs a valid, writing entry with the same rd, and never fires on the zero register.
module reg_match
  import hazard_pkg::*;
(
  input  logic [N-1:0] src,
  input  stage_ent_t   ent,
  output logic         hit
);

  // The load flag is consumed elsewhere; it is carried here only as part of the entry.
  logic unused_ld;
  assign unused_ld = ent.ld;

  assign hit = ent.v & ent.wr & (src == ent.rd) & (src != ZERO_REG);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks destination registers through EX/MEM/WB and drives decode stall plus operand forwarding selects.
// Define HAZARD_FWD_EN for forwarding; otherwise any in-flight producer stalls decode until it leaves WB.
module hazard_scoreboard
  import hazard_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         dec_valid,
  input  logic [N-1:0] dec_rn,
  input  logic [N-1:0] dec_rm,
  input  logic [N-1:0] dec_rd,
  input  logic         dec_wr_en,
  input  logic         dec_load,
  input  logic         flush,
  output logic         stall,
  output logic [1:0]   fwd_a,
  output logic [1:0]   fwd_b
);

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB
  stage_ent_t pipe [3];
  stage_ent_t ent;
  logic [2:0] hit_a;
  logic [2:0] hit_b;
  logic       hazard;
  logic       issue;

  for (genvar g = 0; g < 3; g++) begin : g_match
    reg_match u_match_a (
      .src (dec_rn),
      .ent (pipe[g]),
      .hit (hit_a[g])
    );
    reg_match u_match_b (
      .src (dec_rm),
      .ent (pipe[g]),
      .hit (hit_b[g])
    );
  end

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded in time: one bubble, then MEM forwarding covers it.
  assign hazard = (hit_a[0] | hit_b[0]) & pipe[0].ld;
  assign fwd_a  = dec_valid ? pick_fwd(hit_a) : FWD_RF;
  assign fwd_b  = dec_valid ? pick_fwd(hit_b) : FWD_RF;
`else
  assign hazard = (|hit_a) | (|hit_b);
  assign fwd_a  = FWD_RF;
  assign fwd_b  = FWD_RF;
`endif

  // Flush outranks stall so a killed instruction never holds the front end.
  assign stall = dec_valid & ~flush & hazard;
  assign issue = dec_valid & ~stall & ~flush;

  always_comb begin
    ent = BUBBLE;
    if (issue) begin
      ent.v  = 1'b1;
      ent.rd = dec_rd;
      ent.wr = dec_wr_en & (dec_rd != ZERO_REG);
      ent.ld = dec_load;
    end
  end

  // The EX entry always advances to MEM; flush only replaces what would have entered EX.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pipe[0] <= BUBBLE;
      pipe[1] <= BUBBLE;
      pipe[2] <= BUBBLE;
    end else begin
      pipe[2] <= pipe[1];
      pipe[1] <= pipe[0];
      pipe[0] <= ent;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expected outputs, a monitor pops and compares.
// Expectations follow the HAZARD_FWD_EN setting the bench is compiled with.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       dec_valid = 1'b0;
  logic [4:0] dec_rn = '0;
  logic [4:0] dec_rm = '0;
  logic [4:0] dec_rd = '0;
  logic       dec_wr_en = 1'b0;
  logic       dec_load = 1'b0;
  logic       flush = 1'b0;
  logic       stall;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] a;
    logic [1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .dec_valid (dec_valid),
    .dec_rn    (dec_rn),
    .dec_rm    (dec_rm),
    .dec_rd    (dec_rd),
    .dec_wr_en (dec_wr_en),
    .dec_load  (dec_load),
    .flush     (flush),
    .stall     (stall),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b)
  );

  always #5 clk = ~clk;

  // One decode cycle: drive inputs just after the edge and queue the outputs expected for that cycle.
  // sf/af/bf apply with forwarding enabled, sn is the stall expected without it.
  task automatic applyStimulus(input string name, input logic rst_n, input logic v,
                               input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rd,
                               input logic wr, input logic ld, input logic fl,
                               input logic sf, input logic [1:0] af, input logic [1:0] bf,
                               input logic sn);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = rst_n;
    dec_valid = v;
    dec_rn    = rn;
    dec_rm    = rm;
    dec_rd    = rd;
    dec_wr_en = wr;
    dec_load  = ld;
    flush     = fl;
    e.name = name;
`ifdef HAZARD_FWD_EN
    e.stall = sf;
    e.a     = af;
    e.b     = bf;
`else
    e.stall = sn;
    e.a     = 2'd0;
    e.b     = 2'd0;
`endif
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (stall !== e.stall) begin
      errors++;
      $display("[TB] FAIL %s stall: got %b expected %b", e.name, stall, e.stall);
    end
    checks++;
    if (fwd_a !== e.a) begin
      errors++;
      $display("[TB] FAIL %s fwd_a: got %0d expected %0d", e.name, fwd_a, e.a);
    end
    checks++;
    if (fwd_b !== e.b) begin
      errors++;
      $display("[TB] FAIL %s fwd_b: got %0d expected %0d", e.name, fwd_b, e.b);
    end
  endtask

  // Outputs are combinational on the current decode inputs, so sample mid-cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin : stimulus
    //            name               rst v  rn  rm  rd  wr ld fl  sf af bf sn
    applyStimulus("reset_idle",      0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus("reset_busy",      0, 1,  1,  2,  3, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("after_reset_dep", 1, 1,  3,  3,  4, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("idle",            1, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    applyStimulus("reset_2",         0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    // ALU chain on X1
    applyStimulus("add_x1",          1, 1,  2,  3,  1, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("dep_x1_ex",       1, 1,  1,  3,  2, 1, 0, 0,  0, 1, 0, 1);
    applyStimulus("dep_x1_mem",      1, 1,  1,  6,  7, 1, 0, 0,  0, 2, 0, 1);
    applyStimulus("dep_x1_wb",       1, 1,  1,  6,  8, 1, 0, 0,  0, 3, 0, 1);
    applyStimulus("dep_x2_wb",       1, 1,  1,  2,  9, 0, 0, 0,  0, 0, 3, 0);
    applyStimulus("reset_3",         0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    // load-use on X4
    applyStimulus("ldr_x4",          1, 1,  5,  5,  4, 1, 1, 0,  0, 0, 0, 0);
    applyStimulus("load_use",        1, 1,  4,  4,  5, 1, 0, 0,  1, 1, 1, 1);
    applyStimulus("load_use_mem",    1, 1,  4,  4,  5, 1, 0, 0,  0, 2, 2, 1);
    applyStimulus("load_use_wb",     1, 1,  4,  4,  5, 1, 0, 0,  0, 3, 3, 1);
    applyStimulus("load_gone",       1, 1,  4,  4,  5, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("reset_4",         0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    // zero register and youngest-producer priority
    applyStimulus("wr_x31",          1, 1,  1,  2, 31, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("rd_x31",          1, 1, 31, 31,  7, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("wr_x7_again",     1, 1,  2,  3,  7, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("x7_youngest",     1, 1,  7,  7,  9, 0, 0, 0,  0, 1, 1, 1);
    applyStimulus("reset_5",         0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    // flush beats load-use stall
    applyStimulus("ldr_x4_b",        1, 1,  5,  5,  4, 1, 1, 0,  0, 0, 0, 0);
    applyStimulus("flush_load_use",  1, 1,  4,  6,  5, 1, 0, 1,  0, 1, 0, 0);
    applyStimulus("after_flush",     1, 1,  4,  6,  8, 1, 0, 0,  0, 2, 0, 1);
    applyStimulus("reset_6",         0, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);
    // reset during a load-use stall
    applyStimulus("ldr_x4_c",        1, 1,  5,  5,  4, 1, 1, 0,  0, 0, 0, 0);
    applyStimulus("stall_reset",     0, 1,  4,  4,  5, 1, 0, 0,  1, 1, 1, 1);
    applyStimulus("post_reset",      1, 1,  4,  4,  5, 1, 0, 0,  0, 0, 0, 0);
    applyStimulus("entries_clear",   1, 1,  4,  5,  6, 0, 0, 0,  0, 0, 1, 1);
    applyStimulus("idle_end",        1, 0,  0,  0,  0, 0, 0, 0,  0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
